ptw_sv48: RTL and testbench
===========================

Name: ptw_sv48

Overview:
- Hardware page-table walker for Sv48 that sits directly downstream of the D-TLB and I-TLB miss port.
- Accepts one VA miss at a time and issues up to four 8-byte PTE reads to the memory/cache read port.
- Returns a 4 KiB-granular PPN plus PTE permission bits, or an all-zero fault response, back to the TLB.

Parameters:
- VA_BITS, 48, virtual address width used for the canonical check.
- PPN_BITS, 44, physical page number width.
- OFFSET_BITS, 12, page offset width.
- LEVELS, 4, number of walk levels; fixed for Sv48.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- satp_ppn  in  44  root page-table PPN
- flush  in  1  SFENCE/abort; cancels the walk in progress
- req_valid  in  1  TLB miss request; held high until resp_valid
- req_addr  in  64  faulting VA
- resp_valid  out  1  single-cycle response pulse
- resp_addr  out  64  {8'b0, PPN[43:0], 12'b0}; 0 on fault
- resp_perm_bits  out  8  tlb_perm_bits = PTE[7:0] (D,A,G,U,X,W,R,V); 0 on fault
- mem_req_valid  out  1  PTE read request
- mem_req_addr  out  64  PTE physical address, 8-byte aligned
- mem_req_ready  in  1  memory accepts the request when valid && ready
- mem_resp_valid  in  1  one-beat read data valid; one beat per accepted request
- mem_resp_data  in  64  PTE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, level=3, all outputs 0, internal VA and PPN registers 0.
- States: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE:
  - Latch req_addr when req_valid=1 and resp_valid=0.
  - If req_addr[63:47] is not all-0 and not all-1: go to RESP with a fault; no memory access.
  - Otherwise: ppn <= satp_ppn, level <= 3, go to REQ.
- REQ:
  - mem_req_valid=1 and mem_req_addr = {8'b0, ppn, vpn[level], 3'b000}, where vpn[l] = va[12+9l+8 : 12+9l].
  - Address is held stable until mem_req_ready; on handshake go to WAIT.
- WAIT: on mem_resp_valid, evaluate pte = mem_resp_data:
  - Fault if V=0, or (R=0 and W=1).
  - Leaf if R|X:
    - Fault if the superpage is misaligned, i.e. pte.ppn bits [9*level-1:0] are nonzero.
    - Otherwise PPN = {pte.ppn[43:9*level], va vpn bits [9*level-1:0]}; perms = pte[7:0]; go to RESP.
  - Non-leaf:
    - Level 0: fault.
    - Otherwise ppn <= pte[53:10], level <= level-1, go to REQ.
- Fault response: resp_addr=0, resp_perm_bits=0.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_addr and perm are registered and stable during that cycle; they hold their value afterwards, but only the pulse qualifies them.
- Latency:
  - Fault on canonical check: resp_valid in the cycle after the request is sampled.
  - Otherwise: one cycle after the final mem_resp_valid.
  - With 0-wait ready and 1-cycle memory, a request sampled at cycle 0 gives a leaf at level L with resp_valid at cycle 1 + 2*(4-L).
- Flush:
  - IDLE/RESP: no effect.
  - REQ: keep mem_req_valid and address until the handshake, then go to DRAIN.
  - WAIT without mem_resp_valid: go to DRAIN.
  - WAIT with mem_resp_valid in the same cycle: the data is discarded, go to IDLE.
  - DRAIN: consume one mem_resp_valid, then IDLE.
  - A flushed walk never produces resp_valid.
- One outstanding memory read maximum. mem_resp_valid outside WAIT/DRAIN is ignored.
- The A/D bits are not updated by the walker; they are reported only.

Test Plan:
- 4-level walk: satp_ppn=0x80000, VA=0x401000, 0-wait memory.
  - PTE reads: 0x80000000 returns 0x20000401; 0x80001000 returns 0x20000801; 0x80002010 returns 0x20000C01; 0x80003008 returns 0x48D14CF.
  - Required: resp_valid at cycle 9 with resp_addr=0x12345000 and perm=0xCF.
- 1 GiB superpage: VA=0x40203000.
  - 0x80000000 returns 0x20000401; 0x80001008 returns 0x100000CF.
  - Required: resp_valid at cycle 5 with resp_addr=0x40203000 and perm=0xCF.
- Misaligned superpage: same as above but the second PTE is 0x100004CF (ppn 0x40001) -> resp_addr=0, perm=0.
- Non-canonical VA 0x0001000000000000 -> resp_valid at cycle 1 with resp_addr=0 and perm=0; mem_req_valid never asserts.
- Invalid and stall cases:
  - Level-3 PTE 0x0 (V=0) -> fault after one read.
  - mem_req_ready held low 5 cycles -> mem_req_addr stays stable; resp is delayed 5 cycles.
- Flush and reset:
  - flush in WAIT, data arrives 3 cycles later -> no resp_valid; the next request walks correctly.
  - reset pulsed low mid-REQ -> mem_req_valid=0 immediately, state IDLE.

Source files
------------

// File: rtl/ptw_sv48.sv
// Sv48 hardware page-table walker between the TLB miss port and the memory read port.
// Walks up to four levels, one outstanding PTE read at a time, and returns a leaf PPN/perms or a zero fault.
module ptw_sv48 #(
   parameter int VA_BITS     = 48,
   parameter int PPN_BITS    = 44,
   parameter int OFFSET_BITS = 12,
   parameter int LEVELS      = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PPN_BITS-1:0] satp_ppn,
   input  logic                flush,
   input  logic                req_valid,
   input  logic [63:0]         req_addr,
   output logic                resp_valid,
   output logic [63:0]         resp_addr,
   output logic [7:0]          resp_perm_bits,
   output logic                mem_req_valid,
   output logic [63:0]         mem_req_addr,
   input  logic                mem_req_ready,
   input  logic                mem_resp_valid,
   input  logic [63:0]         mem_resp_data
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_e;

   state_e              state_q, state_d;
   logic [1:0]          level_q, level_d;
   logic [35:0]         vpn_q, vpn_d;
   logic [PPN_BITS-1:0] ppn_q, ppn_d;
   logic [63:0]         resp_addr_q, resp_addr_d;
   logic [7:0]          resp_perm_q, resp_perm_d;
   logic                flush_pend_q, flush_pend_d;

   logic                canonical;
   logic [8:0]          vpn_cur;
   logic [4:0]          shamt;
   logic [PPN_BITS-1:0] lvl_mask, pte_ppn, leaf_ppn;
   logic                pte_v, pte_r, pte_w, pte_x;
   logic                unused_bits;

   assign canonical = (&req_addr[63:VA_BITS-1]) | ~(|req_addr[63:VA_BITS-1]);
   assign shamt     = {3'b000, level_q} * 5'd9;
   assign lvl_mask  = (PPN_BITS'(1) << shamt) - PPN_BITS'(1);
   assign pte_ppn   = mem_resp_data[53:10];
   assign pte_v     = mem_resp_data[0];
   assign pte_r     = mem_resp_data[1];
   assign pte_w     = mem_resp_data[2];
   assign pte_x     = mem_resp_data[3];
   // Superpage leaves take their low PPN bits from the untranslated VPN fields.
   assign leaf_ppn  = (pte_ppn & ~lvl_mask) | ({8'b0, vpn_q} & lvl_mask);
   assign unused_bits = ^{req_addr[OFFSET_BITS-1:0], mem_resp_data[63:54], mem_resp_data[9:8]};

   always_comb begin
      case (level_q)
         2'd3:    vpn_cur = vpn_q[35:27];
         2'd2:    vpn_cur = vpn_q[26:18];
         2'd1:    vpn_cur = vpn_q[17:9];
         default: vpn_cur = vpn_q[8:0];
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         level_q      <= 2'(LEVELS - 1);
         vpn_q        <= '0;
         ppn_q        <= '0;
         resp_addr_q  <= '0;
         resp_perm_q  <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         vpn_q        <= vpn_d;
         ppn_q        <= ppn_d;
         resp_addr_q  <= resp_addr_d;
         resp_perm_q  <= resp_perm_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      level_d      = level_q;
      vpn_d        = vpn_q;
      ppn_d        = ppn_q;
      resp_addr_d  = resp_addr_q;
      resp_perm_d  = resp_perm_q;
      flush_pend_d = flush_pend_q;
      case (state_q)
         IDLE: begin
            if (req_valid && !resp_valid) begin
               vpn_d        = req_addr[47:12];
               flush_pend_d = 1'b0;
               if (!canonical) begin
                  resp_addr_d = '0;
                  resp_perm_d = '0;
                  state_d     = RESP;
               end else begin
                  ppn_d   = satp_ppn;
                  level_d = 2'(LEVELS - 1);
                  state_d = REQ;
               end
            end
         end
         // A flush seen while stalled is remembered so the in-flight read is still drained.
         REQ: begin
            if (flush) flush_pend_d = 1'b1;
            if (mem_req_ready) state_d = (flush || flush_pend_q) ? DRAIN : WAIT;
         end
         WAIT: begin
            if (flush) begin
               state_d = mem_resp_valid ? IDLE : DRAIN;
            end else if (mem_resp_valid) begin
               if (!pte_v || (!pte_r && pte_w)) begin
                  resp_addr_d = '0;
                  resp_perm_d = '0;
                  state_d     = RESP;
               end else if (pte_r || pte_x) begin
                  if ((pte_ppn & lvl_mask) != '0) begin
                     resp_addr_d = '0;
                     resp_perm_d = '0;
                  end else begin
                     resp_addr_d = {{(64-PPN_BITS-OFFSET_BITS){1'b0}}, leaf_ppn, {OFFSET_BITS{1'b0}}};
                     resp_perm_d = mem_resp_data[7:0];
                  end
                  state_d = RESP;
               end else if (level_q == 2'd0) begin
                  resp_addr_d = '0;
                  resp_perm_d = '0;
                  state_d     = RESP;
               end else begin
                  ppn_d   = pte_ppn;
                  level_d = level_q - 2'd1;
                  state_d = REQ;
               end
            end
         end
         DRAIN: begin
            if (mem_resp_valid) state_d = IDLE;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req_valid  = 1'b0;
      mem_req_addr   = '0;
      resp_valid     = (state_q == RESP);
      resp_addr      = resp_addr_q;
      resp_perm_bits = resp_perm_q;
      if (state_q == REQ) begin
         mem_req_valid = 1'b1;
         mem_req_addr  = {8'b0, ppn_q, vpn_cur, 3'b000};
      end
   end

endmodule

// File: tb/tb_ptw_sv48.sv
// Directed bench for ptw_sv48: walks, superpages, faults, stalls, flush and async reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ptw_sv48;

   logic        clk = 1'b0;
   logic        reset;
   logic [43:0] satp_ppn;
   logic        flush;
   logic        req_valid;
   logic [63:0] req_addr;
   logic        resp_valid;
   logic [63:0] resp_addr;
   logic [7:0]  resp_perm_bits;
   logic        mem_req_valid;
   logic [63:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;

   int n_vectors     = 0;
   int n_miscompares = 0;
   int cyc           = 0;
   int start_cyc     = 0;

   ptw_sv48 dut (
      .clk            (clk),
      .reset          (reset),
      .satp_ppn       (satp_ppn),
      .flush          (flush),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .resp_valid     (resp_valid),
      .resp_addr      (resp_addr),
      .resp_perm_bits (resp_perm_bits),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_vectors++;
      assert (observed === expected) else begin
         n_miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // The next rising edge samples the request; latency is counted from it.
   task automatic applyStimulus(input logic [63:0] va);
      req_addr  = va;
      req_valid = 1'b1;
      start_cyc = cyc + 1;
   endtask

   task automatic serveRead(input string tag, input logic [63:0] exp_addr, input logic [63:0] pte, input int stall);
      int waited = 0;
      while (!mem_req_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({tag, " req"}, 64'(mem_req_valid), 64'd1);
      checkOutput({tag, " addr"}, mem_req_addr, exp_addr);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         checkOutput({tag, " stall addr"}, mem_req_addr, exp_addr);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = pte;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
   endtask

   task automatic waitResp(input string tag, input int exp_lat, input logic [63:0] exp_addr, input logic [7:0] exp_perm);
      int waited = 0;
      while (!resp_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({tag, " resp seen"}, 64'(resp_valid), 64'd1);
      checkOutput({tag, " latency"}, 64'(cyc - start_cyc + 1), 64'(exp_lat));
      checkOutput({tag, " resp_addr"}, resp_addr, exp_addr);
      checkOutput({tag, " perm"}, 64'(resp_perm_bits), 64'(exp_perm));
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput({tag, " pulse"}, 64'(resp_valid), 64'd0);
   endtask

   initial begin
      reset          = 1'b0;
      flush          = 1'b0;
      req_valid      = 1'b0;
      req_addr       = '0;
      satp_ppn       = 44'h80000;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;

      @(negedge clk);
      checkOutput("rst resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("rst resp_addr", resp_addr, 64'd0);
      checkOutput("rst perm", 64'(resp_perm_bits), 64'd0);
      checkOutput("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
      checkOutput("rst mem_req_addr", mem_req_addr, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] four-level walk");
      applyStimulus(64'h401000);
      serveRead("walk4 l3", 64'h80000000, 64'h20000401, 0);
      serveRead("walk4 l2", 64'h80001000, 64'h20000801, 0);
      serveRead("walk4 l1", 64'h80002010, 64'h20000C01, 0);
      serveRead("walk4 l0", 64'h80003008, 64'h48D14CF, 0);
      waitResp("walk4", 9, 64'h12345000, 8'hCF);

      $display("[TB] 1 GiB superpage");
      applyStimulus(64'h40203000);
      serveRead("giga l3", 64'h80000000, 64'h20000401, 0);
      serveRead("giga l2", 64'h80001008, 64'h100000CF, 0);
      waitResp("giga", 5, 64'h40203000, 8'hCF);

      $display("[TB] misaligned superpage");
      applyStimulus(64'h40203000);
      serveRead("misal l3", 64'h80000000, 64'h20000401, 0);
      serveRead("misal l2", 64'h80001008, 64'h100004CF, 0);
      waitResp("misal", 5, 64'h0, 8'h00);

      $display("[TB] non-canonical VA");
      applyStimulus(64'h0001000000000000);
      @(negedge clk);
      checkOutput("noncanon no mem", 64'(mem_req_valid), 64'd0);
      waitResp("noncanon", 1, 64'h0, 8'h00);
      checkOutput("noncanon no mem after", 64'(mem_req_valid), 64'd0);

      $display("[TB] invalid level-3 PTE");
      applyStimulus(64'h401000);
      serveRead("inval l3", 64'h80000000, 64'h0, 0);
      waitResp("inval", 3, 64'h0, 8'h00);

      $display("[TB] ready stall");
      applyStimulus(64'h40203000);
      serveRead("stall l3", 64'h80000000, 64'h20000401, 5);
      serveRead("stall l2", 64'h80001008, 64'h100000CF, 0);
      waitResp("stall", 10, 64'h40203000, 8'hCF);

      $display("[TB] flush in WAIT, late data");
      applyStimulus(64'h401000);
      @(negedge clk);
      checkOutput("flushw req", 64'(mem_req_valid), 64'd1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      flush         = 1'b1;
      req_valid     = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("flushw drain resp", 64'(resp_valid), 64'd0);
      checkOutput("flushw drain mem", 64'(mem_req_valid), 64'd0);
      @(negedge clk);
      checkOutput("flushw drain resp2", 64'(resp_valid), 64'd0);
      @(negedge clk);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'h20000401;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      checkOutput("flushw after resp", 64'(resp_valid), 64'd0);
      checkOutput("flushw after mem", 64'(mem_req_valid), 64'd0);
      applyStimulus(64'h40203000);
      serveRead("postflush l3", 64'h80000000, 64'h20000401, 0);
      serveRead("postflush l2", 64'h80001008, 64'h100000CF, 0);
      waitResp("postflush", 5, 64'h40203000, 8'hCF);

      $display("[TB] flush in WAIT with same-cycle data");
      applyStimulus(64'h401000);
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready  = 1'b0;
      flush          = 1'b1;
      req_valid      = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'hCF;
      @(negedge clk);
      flush          = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("flushsame resp", 64'(resp_valid), 64'd0);
         checkOutput("flushsame mem", 64'(mem_req_valid), 64'd0);
         @(negedge clk);
      end

      $display("[TB] reset during REQ");
      applyStimulus(64'h401000);
      @(negedge clk);
      checkOutput("rstreq in REQ", 64'(mem_req_valid), 64'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("rstreq mem_req_valid", 64'(mem_req_valid), 64'd0);
      checkOutput("rstreq mem_req_addr", mem_req_addr, 64'd0);
      checkOutput("rstreq resp_valid", 64'(resp_valid), 64'd0);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      applyStimulus(64'hFFFF000000000000);
      waitResp("rstreq idle", 1, 64'h0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
